rtds_rx_frame_buf: RTL and testbench

RTDS_RX_FRAME_BUF -- requirements
Module: rtds_rx_frame_buf

---
 rtl/rtds_rx_frame_buf.sv | 147 ++++++++++++++
 tb/tb_rtds_rx_frame_buf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtds_rx_frame_buf.sv
// Store-and-forward RX frame buffer: a frame becomes visible to the reader only once its tlast beat is stored.
// Optional statistics counters are built only when RX_FRAME_STATS_EN is defined.
module rtds_rx_frame_buf #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_aresetn,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        frame_dropped,
  output logic        buf_empty,
  output logic [31:0] stat_frames_rx,
  output logic [31:0] stat_frames_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic {ACCEPT, DISCARD} wr_state_t;

  logic [32:0]   mem [DEPTH];
  logic [32:0]   ram_q;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  wr_state_t     state;
  logic          drop_q;
  logic          full, wr_en, commit_en, drop_set;
  logic          out_valid, out_last, pf_valid, pf_last, rd_pend;
  logic [31:0]   out_data, pf_data;
  logic          pop, fetch_en;
  logic [1:0]    occ;

  // rd_ptr only advances when a word leaves the output register, so words held
  // in the prefetch path still reserve their RAM slot for the full test.
  assign full      = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign wr_en     = s_axis_tvalid && (state == ACCEPT) && !full;
  assign commit_en = wr_en && s_axis_tlast;
  assign drop_set  = s_axis_tvalid && s_axis_tlast && ((state == DISCARD) || full);

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= drop_set;
      case (state)
        ACCEPT: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (commit_en) commit_ptr <= wr_ptr + PW'(1);
          end else if (s_axis_tvalid) begin
            wr_ptr <= commit_ptr;
            if (!s_axis_tlast) state <= DISCARD;
          end
        end
        DISCARD: begin
          if (s_axis_tvalid && s_axis_tlast) state <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (fetch_en) ram_q <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
  end

  // At most two words (output + prefetch) may be held or in flight at once.
  assign pop      = out_valid && m_axis_tready;
  assign occ      = 2'(out_valid) + 2'(pf_valid) + 2'(rd_pend) - 2'(pop);
  assign fetch_en = (fetch_ptr != commit_ptr) && (occ < 2'd2);

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      pf_last   <= 1'b0;
    end else begin
      rd_pend <= fetch_en;
      if (fetch_en) fetch_ptr <= fetch_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (!out_valid || pop) begin
        if (pf_valid) begin
          out_valid <= 1'b1;
          out_data  <= pf_data;
          out_last  <= pf_last;
          if (rd_pend) begin
            pf_data <= ram_q[31:0];
            pf_last <= ram_q[32];
          end else begin
            pf_valid <= 1'b0;
          end
        end else if (rd_pend) begin
          out_valid <= 1'b1;
          out_data  <= ram_q[31:0];
          out_last  <= ram_q[32];
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        pf_valid <= 1'b1;
        pf_data  <= ram_q[31:0];
        pf_last  <= ram_q[32];
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign frame_dropped = drop_q;
  assign buf_empty     = (rd_ptr == commit_ptr) && !out_valid;

`ifdef RX_FRAME_STATS_EN
  logic [31:0] rx_cnt, drop_cnt;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit_en) rx_cnt <= rx_cnt + 32'd1;
      if (drop_set) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign stat_frames_rx   = rx_cnt;
  assign stat_frames_drop = drop_cnt;
`else
  assign stat_frames_rx   = '0;
  assign stat_frames_drop = '0;
`endif

endmodule

// File: tb/tb_rtds_rx_frame_buf.sv
// Bench for rtds_rx_frame_buf at ADDR_WIDTH=4: cycle table for the basic frame, then directed multi-cycle sequences.
module tb_rtds_rx_frame_buf;

  logic        m_axis_aclk = 1'b0;
  logic        m_axis_aresetn;
  logic        s_axis_tvalid, s_axis_tlast, m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, frame_dropped, buf_empty;
  logic [31:0] m_axis_tdata, stat_frames_rx, stat_frames_drop;

  int checks = 0;
  int failures = 0;
  int drop_seen = 0;
  bit mon_en = 0;
  logic [32:0] exp_q[$];

  rtds_rx_frame_buf #(.ADDR_WIDTH(4)) dut (
    .m_axis_aclk(m_axis_aclk), .m_axis_aresetn(m_axis_aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .frame_dropped(frame_dropped), .buf_empty(buf_empty),
    .stat_frames_rx(stat_frames_rx), .stat_frames_drop(stat_frames_drop)
  );

  always #5 m_axis_aclk = ~m_axis_aclk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
`ifdef RX_FRAME_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Monitor: outputs sampled on the falling edge, where valid/ready are settled for the next rising edge.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;
  always @(negedge m_axis_aclk) begin
    if (m_axis_aresetn) begin
      if (frame_dropped) drop_seen++;
      if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_word});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
      if (mon_en && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got=0x%0h expected no beat", {m_axis_tlast, m_axis_tdata});
        end else begin
          chk("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge m_axis_aclk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_dropped", frame_dropped, 0);
    chk("rst_empty", buf_empty, 1);
    chk("rst_stat_rx", stat_frames_rx, 0);
    chk("rst_stat_drop", stat_frames_drop, 0);
  endtask

  task automatic apply_reset();
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
    #1;
    m_axis_aresetn = 0;
    #1;
    check_reset_vals();
    exp_q.delete();
    tick();
    tick();
    m_axis_aresetn = 1;
  endtask

  task automatic send_frame(input logic [31:0] base, input int len, input bit keep);
    for (int i = 0; i < len; i++) begin
      if (keep) exp_q.push_back({(i == len - 1), base + 32'(i)});
      s_axis_tvalid = 1;
      s_axis_tdata  = base + 32'(i);
      s_axis_tlast  = (i == len - 1);
      tick();
    end
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_empty;
  } vec_t;

  vec_t vt[10];
  int   d0;

  initial begin
    // 4-beat frame, tready=1: tlast sampled at edge 4, first output word visible after edge 6.
    vt[0] = '{1, 32'h11, 0, 0, 0, 0, 1};
    vt[1] = '{1, 32'h22, 0, 0, 0, 0, 1};
    vt[2] = '{1, 32'h33, 0, 0, 0, 0, 1};
    vt[3] = '{1, 32'h44, 1, 0, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{0, 0, 0, 1, 32'h11, 0, 0};
    vt[6] = '{0, 0, 0, 1, 32'h22, 0, 0};
    vt[7] = '{0, 0, 0, 1, 32'h33, 0, 0};
    vt[8] = '{0, 0, 0, 1, 32'h44, 1, 0};
    vt[9] = '{0, 0, 0, 0, 0, 0, 1};

    m_axis_aresetn = 0;
    s_axis_tvalid  = 0;
    s_axis_tdata   = 0;
    s_axis_tlast   = 0;
    m_axis_tready  = 0;
    tick();
    tick();
    check_reset_vals();
    m_axis_aresetn = 1;

    m_axis_tready = 1;
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = vt[i].vld;
      s_axis_tdata  = vt[i].data;
      s_axis_tlast  = vt[i].last;
      tick();
      chk($sformatf("vec%0d", i),
          {m_axis_tvalid, m_axis_tvalid ? m_axis_tdata : 32'h0, m_axis_tvalid & m_axis_tlast, buf_empty},
          {vt[i].e_vld, vt[i].e_data, vt[i].e_last, vt[i].e_empty});
    end
    chk("basic_stat_rx", stat_frames_rx, st(1));
    mon_en = 1;

    // 10-beat frame buffered, 8-beat frame overflows and is dropped while stalled.
    apply_reset();
    m_axis_tready = 0;
    d0 = drop_seen;
    send_frame(32'hA0, 10, 1);
    send_frame(32'hB0, 8, 0);
    repeat (3) tick();
    chk("ovf_drop_pulses", drop_seen - d0, 1);
    chk("ovf_stat_drop", stat_frames_drop, st(1));
    chk("ovf_stat_rx", stat_frames_rx, st(1));
    chk("ovf_stalled_head", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'hA0});
    m_axis_tready = 1;
    wait_drain(40, "ovf_drain");
    repeat (10) tick();
    chk("ovf_empty", buf_empty, 1);

    // Exactly DEPTH words fit; a 1-beat frame arriving while full is dropped in ACCEPT.
    apply_reset();
    m_axis_tready = 0;
    d0 = drop_seen;
    send_frame(32'h200, 16, 1);
    send_frame(32'h300, 1, 0);
    repeat (2) tick();
    chk("full_tlast_drop", drop_seen - d0, 1);
    m_axis_tready = 1;
    wait_drain(40, "full_drain");
    send_frame(32'h400, 1, 1);
    wait_drain(10, "single_beat_drain");
    chk("full_stat_rx", stat_frames_rx, st(2));
    chk("full_stat_drop", stat_frames_drop, st(1));

    // Oversized frame never reaches the output.
    apply_reset();
    m_axis_tready = 1;
    d0 = drop_seen;
    send_frame(32'h500, 20, 0);
    chk("long_empty", buf_empty, 1);
    repeat (5) tick();
    chk("long_drop", drop_seen - d0, 1);
    chk("long_stat_drop", stat_frames_drop, st(1));
    chk("long_stat_rx", stat_frames_rx, st(0));

    // Back-to-back single-beat frames with tready toggling.
    apply_reset();
    m_axis_tready = 1;
    fork
      for (int k = 0; k < 12; k++) send_frame(32'h600 + 32'(k), 1, 1);
      repeat (30) begin
        m_axis_tready = ~m_axis_tready;
        tick();
      end
    join
    m_axis_tready = 1;
    wait_drain(50, "b2b_drain");
    chk("b2b_stat_rx", stat_frames_rx, st(12));

    // Reset mid-readout, then mid-frame, then a clean frame.
    apply_reset();
    m_axis_tready = 1;
    send_frame(32'h700, 10, 1);
    for (int n = 0; n < 30 && exp_q.size() > 7; n++) tick();
    chk("midread_progress", exp_q.size() <= 7, 1);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1;
      s_axis_tdata  = 32'h800 + 32'(i);
      s_axis_tlast  = 0;
      tick();
    end
    apply_reset();
    send_frame(32'h900, 6, 1);
    wait_drain(20, "post_reset_drain");
    chk("post_reset_stat_rx", stat_frames_rx, st(1));
    repeat (3) tick();
    chk("post_reset_empty", buf_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
